// File: rtl/mem_access_unit.sv
// Load/store sequencer between the control/ALU and a word-wide DataMemory.
// Sub-word stores use read-modify-write; loads are lane-extracted and extended.
module mem_access_unit #(
    parameter int ADDR_W      = 15,
    parameter int DEPTH_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    output logic              ready,
    input  logic              op_store,
    input  logic [1:0]        size,
    input  logic              load_signed,
    input  logic [31:0]       addr,
    input  logic [31:0]       store_data,
    output logic              done,
    output logic [31:0]       load_data,
    output logic              fault,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);

    state_t            state, state_next;
    logic              accept;
    logic              bad;
    logic              op_store_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic [1:0]        lane_q;
    logic [31:0]       store_data_q;
    logic              fault_q;
    logic [31:0]       load_data_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;

    function automatic logic [31:0] extract_lane(input logic [31:0] word, input logic [1:0] sz,
                                                 input logic [1:0] lane, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (sz)
            2'b00:   r = {{24{sgn & b[7]}}, b};
            2'b01:   r = {{16{sgn & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [31:0] data,
                                               input logic [1:0] sz, input logic [1:0] lane);
        logic [31:0] r;
        r = word;
        case (sz)
            2'b00:   r[{lane, 3'b000} +: 8]     = data[7:0];
            2'b01:   r[{lane[1], 4'b0000} +: 16] = data[15:0];
            default: r = data;
        endcase
        return r;
    endfunction

    assign accept = req && (state == IDLE);

    // Misaligned, illegal size or out-of-range index all complete immediately as a fault
    always_comb begin
        bad = 1'b0;
        case (size)
            2'b11:   bad = 1'b1;
            2'b01:   bad = addr[0];
            2'b10:   bad = (addr[1:0] != 2'b00);
            default: bad = 1'b0;
        endcase
        if (addr[31:2] >= DEPTH_LIM)
            bad = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (bad)
                        state_next = DONE;
                    else if (op_store && size == 2'b10)
                        state_next = WR;
                    else
                        state_next = RD;
                end
            end
            RD:      state_next = op_store_q ? WR : DONE;
            WR:      state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ready  = (state == IDLE);
        done   = (state == DONE);
        mem_we = (state == WR);
    end

    // Request fields only matter between accept and DONE, so they carry no reset
    always_ff @(posedge clk) begin
        if (accept) begin
            op_store_q   <= op_store;
            size_q       <= size;
            signed_q     <= load_signed;
            lane_q       <= addr[1:0];
            store_data_q <= store_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fault_q     <= 1'b0;
            load_data_q <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        mem_addr_q <= addr[ADDR_W+1:2];
                        fault_q    <= bad;
                        if (bad)
                            load_data_q <= '0;
                        else if (op_store)
                            mem_wdata_q <= store_data;
                    end
                end
                RD: begin
                    if (op_store_q)
                        mem_wdata_q <= merge_lane(mem_rdata, store_data_q, size_q, lane_q);
                    else
                        load_data_q <= extract_lane(mem_rdata, size_q, lane_q, signed_q);
                end
                DONE:    fault_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign fault     = fault_q;
    assign load_data = load_data_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
